// File: rtl/mac_pkg.sv
// ---------------------------------------------------------------------------
// mac_pkg
// Shared definitions for the floating-point MAC sequencer.
//   state_t      : sequencer FSM states (IDLE / RUN / DRAIN / HOLD)
//   DEF_MUL_LAT  : default multiplier latency (operand accept -> adder input)
//   DEF_ADD_LAT  : default adder latency (add issue -> accumulator write)
//   DEF_CNT_W    : default width of the job length / element counters
// ---------------------------------------------------------------------------
package mac_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam int DEF_MUL_LAT = 3;
    localparam int DEF_ADD_LAT = 4;
    localparam int DEF_CNT_W   = 16;

endpackage

// File: rtl/mac_vld_pipe.sv
// ---------------------------------------------------------------------------
// mac_vld_pipe
// Shift register carrying per-element valid/tag bits alongside a datapath
// pipeline, so that a bit entering on d appears on q exactly DEPTH cycles
// later.
// Ports:
//   clk    in   1   rising-edge clock
//   clr_n  in   1   synchronous clear, active low (empties every stage)
//   d      in   W   bits entering stage 0
//   q      out  W   bits leaving stage DEPTH-1
// ---------------------------------------------------------------------------
module mac_vld_pipe #(
    parameter int DEPTH = 1,
    parameter int W     = 1
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] sr [DEPTH];

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                sr[i] <= '0;
            end
        end else begin
            sr[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    assign q = sr[DEPTH-1];

endmodule

// File: rtl/mac_seq_ctrl.sv
// ---------------------------------------------------------------------------
// mac_seq_ctrl
// Sequencer for the floating-point MAC datapath. Runs one dot-product job of
// len elements through the multiplier and the pipelined adder into the
// accumulator, spacing operand accepts so every add sees the previous
// accumulate result, then presents the final sum with a valid/ready handshake.
//
// Optional feature: define MAC_PERF_CNT_EN to add the stall_cnt port and its
// counter. With the macro undefined the port and counter do not exist.
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst_n      in   1      synchronous reset, active low
//   start      in   1      job start pulse, sampled only in IDLE
//   len        in   CNT_W  element count, captured on accepted start
//   busy       out  1      high in every state except IDLE
//   in_valid   in   1      operand pair valid
//   in_ready   out  1      operand pair accepted when in_valid & in_ready
//   mul_en     out  1      multiplier stage-0 capture enable
//   add_issue  out  1      product valid at adder input
//   acc_zero   out  1      with add_issue: first element, adder uses +0
//   acc_wr     out  1      adder result valid, accumulator loads it
//   acc_clr    out  1      one-cycle accumulator clear for a len==0 job
//   out_valid  out  1      final sum in accumulator valid
//   out_ready  in   1      consumer accepts sum
//   done       out  1      one-cycle pulse on out_valid & out_ready
//   stall_cnt  out  CNT_W  (MAC_PERF_CNT_EN) RUN cycles with in_valid & !in_ready
//   fsm_state  out  2      current FSM state, for observation
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. valid must not depend on ready; a source holding valid with
// ready low keeps its data stable until the transfer (in_valid side), and
// out_valid stays high until out_ready is seen.
// ---------------------------------------------------------------------------
module mac_seq_ctrl
    import mac_pkg::*;
#(
    parameter int MUL_LAT = DEF_MUL_LAT,
    parameter int ADD_LAT = DEF_ADD_LAT,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             mul_en,
    output logic             add_issue,
    output logic             acc_zero,
    output logic             acc_wr,
    output logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             done,
`ifdef MAC_PERF_CNT_EN
    output logic [CNT_W-1:0] stall_cnt,
`endif
    output state_t           fsm_state
);

    // gap only ever holds values up to ADD_LAT-1
    localparam int GAP_W = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] issued;
    logic [CNT_W-1:0] retired;
    logic [GAP_W-1:0] gap;

    logic             start_go;
    logic             accept;
    logic             last_accept;
    logic             last_retire;
    logic [1:0]       mul_q;
    logic             add_q;

    assign start_go    = (state == IDLE) && start;
    assign accept      = in_valid && in_ready;
    // len_q is never zero while in RUN/DRAIN, so len_q-1 is the last index
    assign last_accept = accept && (issued == len_q - CNT_W'(1));
    assign last_retire = acc_wr && (retired == len_q - CNT_W'(1));

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (len != '0) ? RUN : HOLD;
                end
            end
            RUN: begin
                if (last_accept) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (last_retire) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy      = (state != IDLE);
        in_ready  = (state == RUN) && (gap == '0) && (issued < len_q);
        mul_en    = in_valid && in_ready;
        add_issue = mul_q[0];
        acc_zero  = mul_q[0] && mul_q[1];
        acc_wr    = add_q;
        acc_clr   = (state == IDLE) && start && (len == '0);
        out_valid = (state == HOLD);
        done      = (state == HOLD) && out_ready;
        fsm_state = state;
    end

    // ---------------- job counters and issue spacing ----------------
    // After each accept, gap blocks further accepts for ADD_LAT-1 cycles so
    // that consecutive adds are ADD_LAT cycles apart on the accumulator.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            len_q   <= '0;
            issued  <= '0;
            retired <= '0;
            gap     <= '0;
        end else if (start_go && (len != '0)) begin
            len_q   <= len;
            issued  <= '0;
            retired <= '0;
            gap     <= '0;
        end else begin
            if (accept) begin
                issued <= issued + CNT_W'(1);
                gap    <= GAP_W'(ADD_LAT - 1);
            end else if (gap != '0) begin
                gap <= gap - GAP_W'(1);
            end
            if (acc_wr) begin
                retired <= retired + CNT_W'(1);
            end
        end
    end

    // ---------------- valid tracking pipes ----------------
    // Multiplier pipe carries {first-element tag, valid}; the tag only needs
    // to reach the adder input, so the adder pipe carries valid alone.
    mac_vld_pipe #(
        .DEPTH (MUL_LAT),
        .W     (2)
    ) u_mul_pipe (
        .clk   (clk),
        .clr_n (rst_n),
        .d     ({accept && (issued == '0), accept}),
        .q     (mul_q)
    );

    mac_vld_pipe #(
        .DEPTH (ADD_LAT),
        .W     (1)
    ) u_add_pipe (
        .clk   (clk),
        .clr_n (rst_n),
        .d     (add_issue),
        .q     (add_q)
    );

`ifdef MAC_PERF_CNT_EN
    // ---------------- stall counter ----------------
    logic [CNT_W-1:0] stall_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (start_go) begin
            stall_q <= '0;
        end else if ((state == RUN) && in_valid && !in_ready && (stall_q != '1)) begin
            stall_q <= stall_q + CNT_W'(1);
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mac_seq_ctrl
// Self-checking bench for mac_seq_ctrl (default parameters). Inputs are
// driven 1 time unit after the rising edge; outputs are observed on the
// falling edge. The monitor predicts add_issue / acc_wr timing from each
// observed accept and compares when the DUT produces them.
// ---------------------------------------------------------------------------
module tb_mac_seq_ctrl;
    import mac_pkg::*;

    localparam int MUL_LAT = 3;
    localparam int ADD_LAT = 4;
    localparam int CNT_W   = 16;
    localparam int PIPE_LAT = MUL_LAT + ADD_LAT + 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- DUT ----------------
    logic             start = 1'b0;
    logic [CNT_W-1:0] len = '0;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic             busy, in_ready, mul_en, add_issue, acc_zero, acc_wr;
    logic             acc_clr, out_valid, done;
    state_t           fsm_state;
`ifdef MAC_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt;
`endif

    mac_seq_ctrl #(
        .MUL_LAT (MUL_LAT),
        .ADD_LAT (ADD_LAT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mul_en    (mul_en),
        .add_issue (add_issue),
        .acc_zero  (acc_zero),
        .acc_wr    (acc_wr),
        .acc_clr   (acc_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .done      (done),
`ifdef MAC_PERF_CNT_EN
        .stall_cnt (stall_cnt),
`endif
        .fsm_state (fsm_state)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- scoreboard / monitor ----------------
    logic [32:0] add_exp_q[$];   // {expected add_issue cycle, expected acc_zero}
    logic [31:0] acc_exp_q[$];   // expected acc_wr cycle
    int          mul_log[$];     // cycles of observed accepts in current job
    int          n_accwr = 0;
    int          n_clr = 0;
    int          n_done = 0;
    int          clr_cyc = 0;
    int          ov_cyc = 0;
    bit          ov_seen = 1'b0;
    bit          first_pending = 1'b0;

    always @(negedge clk) begin
        logic [32:0] e;
        if (!rst_n) begin
            add_exp_q.delete();
            acc_exp_q.delete();
        end else begin
            if (mul_en) begin
                mul_log.push_back(cyc);
                add_exp_q.push_back({32'(cyc + MUL_LAT), first_pending});
                first_pending = 1'b0;
            end
            if (acc_zero && !add_issue) begin
                check("acc_zero_without_issue", 32'(acc_zero), 32'd0);
            end
            if (add_issue) begin
                if (add_exp_q.size() == 0) begin
                    check("unexpected_add_issue", 32'(add_issue), 32'd0);
                end else begin
                    e = add_exp_q.pop_front();
                    check("add_issue_cycle", 32'(cyc), e[32:1]);
                    check("acc_zero", 32'(acc_zero), 32'(e[0]));
                end
                acc_exp_q.push_back(32'(cyc + ADD_LAT));
            end
            if (acc_wr) begin
                n_accwr++;
                if (acc_exp_q.size() == 0) begin
                    check("unexpected_acc_wr", 32'(acc_wr), 32'd0);
                end else begin
                    check("acc_wr_cycle", 32'(cyc), acc_exp_q.pop_front());
                end
            end
            if (acc_clr) begin
                n_clr++;
                clr_cyc = cyc;
            end
            if (done) n_done++;
            if (out_valid && !ov_seen) begin
                ov_seen = 1'b1;
                ov_cyc  = cyc;
            end
        end
    end

    // ---------------- driver tasks ----------------
    // All tasks are entered and left 1 time unit after a rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        @(negedge clk);
        check({tag, "_outputs"}, 32'({busy, in_ready, mul_en, add_issue, acc_zero,
                                     acc_wr, acc_clr, out_valid, done}), 32'd0);
        check({tag, "_state"}, 32'(fsm_state), 32'(IDLE));
        step();
    endtask

    task automatic wait_ov(input int budget);
        int k = 0;
        while (!ov_seen && k < budget) begin
            step();
            k++;
        end
        if (!ov_seen) check("out_valid_timeout", 32'(ov_seen), 32'd1);
    endtask

    task automatic run_job(input int n, input int hold, input bit poke_start, input int exp_stall);
        int k = 0;
        int t_start;
        mul_log.delete();
        n_accwr = 0;
        n_clr = 0;
        n_done = 0;
        ov_seen = 1'b0;
        first_pending = 1'b1;
        len = CNT_W'(n);
        start = 1'b1;
        in_valid = (n != 0);
        t_start = cyc;
        step();
        start = 1'b0;
        if (n != 0) begin
            while (mul_log.size() < n && k < 300) begin
                step();
                k++;
            end
            in_valid = 1'b0;
            check("accept_count", 32'(mul_log.size()), 32'(n));
        end
        wait_ov(100);

        if (n == 0) begin
            check("len0_clr_count", 32'(n_clr), 32'd1);
            check("len0_clr_cycle", 32'(clr_cyc), 32'(t_start));
            check("len0_out_valid_cycle", 32'(ov_cyc), 32'(t_start + 1));
            check("len0_no_accept", 32'(mul_log.size()), 32'd0);
        end else if (mul_log.size() == n) begin
            check("first_accept_cycle", 32'(mul_log[0]), 32'(t_start + 1));
            for (int i = 1; i < n; i++) begin
                check("accept_spacing", 32'(mul_log[i] - mul_log[i-1]), 32'(ADD_LAT));
            end
            check("out_valid_latency", 32'(ov_cyc - mul_log[n-1]), 32'(PIPE_LAT));
            check("acc_wr_count", 32'(n_accwr), 32'(n));
            check("no_clr", 32'(n_clr), 32'd0);
        end

        // consumer stalls in HOLD; a start pulse here must be ignored
        for (int i = 0; i < hold; i++) begin
            if (poke_start && i == 1) begin
                start = 1'b1;
                len = CNT_W'(1);
            end
            @(negedge clk);
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_no_done", 32'(done), 32'd0);
            check("hold_state", 32'(fsm_state), 32'(HOLD));
            step();
            start = 1'b0;
        end

        out_ready = 1'b1;
        @(negedge clk);
        check("handshake_done", 32'(done), 32'd1);
        check("handshake_out_valid", 32'(out_valid), 32'd1);
`ifdef MAC_PERF_CNT_EN
        check("stall_cnt", 32'(stall_cnt), 32'(exp_stall));
`endif
        step();
        out_ready = 1'b0;
        @(negedge clk);
        check("after_done_state", 32'(fsm_state), 32'(IDLE));
        check("after_done_busy", 32'(busy), 32'd0);
        check("after_done_out_valid", 32'(out_valid), 32'd0);
        check("done_count", 32'(n_done), 32'd1);
        check("accepts_after_job", 32'(mul_log.size()), 32'(n));
        step();
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        int n_rand;
        int k;

        // reset state
        rst_n = 1'b0;
        repeat (3) step();
        check_all_zero("reset");
        rst_n = 1'b1;
        step();

        // single element
        run_job(1, 0, 1'b0, 0);
        // three elements: accepts 4 cycles apart, each blocked 3 cycles
        run_job(3, 0, 1'b0, 6);
        // empty job
        run_job(0, 0, 1'b0, 0);
        // consumer holds off 5 cycles, stray start while waiting
        run_job(1, 5, 1'b1, 0);
        // two elements: 3 stall cycles
        run_job(2, 0, 1'b0, 3);
        // random length and consumer delay
        n_rand = $urandom_range(4, 6);
        run_job(n_rand, $urandom_range(0, 3), 1'b0, 3 * (n_rand - 1));

        // reset in the middle of DRAIN aborts the job
        mul_log.delete();
        first_pending = 1'b1;
        len = CNT_W'(3);
        start = 1'b1;
        in_valid = 1'b1;
        step();
        start = 1'b0;
        k = 0;
        while (mul_log.size() < 3 && k < 300) begin
            step();
            k++;
        end
        in_valid = 1'b0;
        check("abort_accept_count", 32'(mul_log.size()), 32'd3);
        step();
        @(negedge clk);
        check("abort_in_drain", 32'(fsm_state), 32'(DRAIN));
        step();
        rst_n = 1'b0;
        step();
        check_all_zero("abort");
        rst_n = 1'b1;
        n_accwr = 0;
        n_done = 0;
        ov_seen = 1'b0;
        repeat (15) step();
        check("abort_no_acc_wr", 32'(n_accwr), 32'd0);
        check("abort_no_out_valid", 32'(ov_seen), 32'd0);
        check("abort_no_done", 32'(n_done), 32'd0);

        // job after abort runs normally
        run_job(2, 1, 1'b0, 3);

        check("add_queue_empty", 32'(add_exp_q.size()), 32'd0);
        check("acc_queue_empty", 32'(acc_exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
